// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: opcodes, ALU/write-back codes, immediate formats.
package rv_pkg;

    // Must match the fetch-stage reset PC.
    localparam logic [31:0] RESET_PC = 32'd128;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'd0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

    // Bit 30 only distinguishes SUB in register-register form; SRA/SRAI in both forms.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic bit30,
                                           input logic is_reg);
        alu_op_e op;
        case (funct3)
            3'd0:    op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = bit30 ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// 32x32 register file: two read ports, one write port, x0 hardwired to zero,
// same-cycle write-through to the read ports.
module rv_regfile (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);

    logic [31:0] r_regs [1:31];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (i_we && i_waddr != 5'd0) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata1 = 32'd0;
        o_rdata2 = 32'd0;
        if (i_raddr1 != 5'd0) begin
            o_rdata1 = (i_we && i_waddr == i_raddr1) ? i_wdata : r_regs[i_raddr1];
        end
        if (i_raddr2 != 5'd0) begin
            o_rdata2 = (i_we && i_waddr == i_raddr2) ? i_wdata : r_regs[i_raddr2];
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decode, register read, early JAL redirect,
// and the registered ID/EX bundle for execute.
module id_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pipe_pc,
    input  logic [31:0] pipe_pc4,
    input  logic [31:0] pipe_data,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        control_j,
    output logic [31:0] pc_j,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_rs1_data,
    output logic [31:0] id_rs2_data,
    output logic [31:0] id_imm,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [2:0]  id_funct3,
    output logic [3:0]  id_alu_op,
    output logic        id_alu_src_imm,
    output logic        id_alu_src_pc,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_reg_write,
    output logic        id_branch,
    output logic        id_jalr,
    output logic        id_illegal,
    output logic [1:0]  id_wb_sel
);
    import rv_pkg::*;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_imm;
    logic [31:0] w_imm_j;
    logic        w_legal;
    logic        w_is_jal;
    logic        w_bubble;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_branch;
    logic        w_jalr;
    logic        w_alu_src_imm;
    logic        w_alu_src_pc;
    logic [1:0]  w_wb_sel;
    alu_op_e     w_alu_op;
    imm_fmt_e    w_imm_fmt;

    assign w_opcode = pipe_data[6:0];
    assign w_rd     = pipe_data[11:7];
    assign w_rs1    = pipe_data[19:15];
    assign w_rs2    = pipe_data[24:20];

    always_comb begin
        w_legal       = 1'b1;
        w_reg_write   = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_branch      = 1'b0;
        w_jalr        = 1'b0;
        w_alu_src_imm = 1'b0;
        w_alu_src_pc  = 1'b0;
        w_wb_sel      = WB_ALU;
        w_alu_op      = ALU_ADD;
        w_imm_fmt     = IMM_NONE;
        case (w_opcode)
            OPC_LUI: begin
                w_reg_write = 1'b1; w_imm_fmt = IMM_U; w_alu_op = ALU_PASSB; w_alu_src_imm = 1'b1;
            end
            OPC_AUIPC: begin
                w_reg_write = 1'b1; w_imm_fmt = IMM_U; w_alu_src_imm = 1'b1; w_alu_src_pc = 1'b1;
            end
            OPC_JAL: begin
                w_reg_write = 1'b1; w_imm_fmt = IMM_J; w_wb_sel = WB_PC4;
            end
            OPC_JALR: begin
                w_reg_write = 1'b1; w_imm_fmt = IMM_I; w_jalr = 1'b1; w_wb_sel = WB_PC4;
                w_alu_src_imm = 1'b1;
            end
            OPC_BRANCH: begin
                w_branch = 1'b1; w_imm_fmt = IMM_B; w_alu_op = ALU_SUB;
            end
            OPC_LOAD: begin
                w_reg_write = 1'b1; w_mem_read = 1'b1; w_imm_fmt = IMM_I; w_wb_sel = WB_MEM;
                w_alu_src_imm = 1'b1;
            end
            OPC_STORE: begin
                w_mem_write = 1'b1; w_imm_fmt = IMM_S; w_alu_src_imm = 1'b1;
            end
            OPC_OPIMM: begin
                w_reg_write = 1'b1; w_imm_fmt = IMM_I; w_alu_src_imm = 1'b1;
                w_alu_op = alu_decode(pipe_data[14:12], pipe_data[30], 1'b0);
            end
            OPC_OP: begin
                w_reg_write = 1'b1;
                w_alu_op = alu_decode(pipe_data[14:12], pipe_data[30], 1'b1);
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_imm    = gen_imm(pipe_data, w_imm_fmt);
    assign w_imm_j  = gen_imm(pipe_data, IMM_J);
    assign w_is_jal = (w_opcode == OPC_JAL);
    assign w_bubble = (pipe_data == 32'd0) || ex_redirect || !w_legal;

    // A resolved EX redirect outranks an early JAL in the same cycle.
    assign control_j = ex_redirect | w_is_jal;
    assign pc_j      = ex_redirect ? ex_target : pipe_pc + w_imm_j;

    rv_regfile u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rs1_data),
        .o_rdata2 (w_rs2_data),
        .i_we     (wb_we),
        .i_waddr  (wb_rd),
        .i_wdata  (wb_data)
    );

    // Data fields load unconditionally; only control bits are squashed on a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_pc          <= 32'd0;
            id_pc4         <= 32'd0;
            id_rs1_data    <= 32'd0;
            id_rs2_data    <= 32'd0;
            id_imm         <= 32'd0;
            id_rs1         <= 5'd0;
            id_rs2         <= 5'd0;
            id_rd          <= 5'd0;
            id_funct3      <= 3'd0;
            id_alu_op      <= 4'd0;
            id_alu_src_imm <= 1'b0;
            id_alu_src_pc  <= 1'b0;
            id_mem_read    <= 1'b0;
            id_mem_write   <= 1'b0;
            id_reg_write   <= 1'b0;
            id_branch      <= 1'b0;
            id_jalr        <= 1'b0;
            id_illegal     <= 1'b0;
            id_wb_sel      <= 2'd0;
        end else begin
            id_pc          <= pipe_pc;
            id_pc4         <= pipe_pc4;
            id_rs1_data    <= w_rs1_data;
            id_rs2_data    <= w_rs2_data;
            id_imm         <= w_imm;
            id_rs1         <= w_rs1;
            id_rs2         <= w_rs2;
            id_rd          <= w_rd;
            id_funct3      <= pipe_data[14:12];
            id_alu_op      <= w_alu_op;
            id_alu_src_imm <= w_alu_src_imm;
            id_alu_src_pc  <= w_alu_src_pc;
            id_wb_sel      <= w_wb_sel;
            id_mem_read    <= w_mem_read  && !w_bubble;
            id_mem_write   <= w_mem_write && !w_bubble;
            id_reg_write   <= w_reg_write && !w_bubble && (w_rd != 5'd0);
            id_branch      <= w_branch    && !w_bubble;
            id_jalr        <= w_jalr      && !w_bubble;
            id_illegal     <= !w_legal && (pipe_data != 32'd0) && !ex_redirect;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: randomized and directed instructions checked
// against a behavioural decode/register-file model.
module tb_id_stage;

    logic        clk;
    logic        reset_n;
    logic [31:0] pipe_pc, pipe_pc4, pipe_data;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        control_j;
    logic [31:0] pc_j, id_pc, id_pc4, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic [3:0]  id_alu_op;
    logic        id_alu_src_imm, id_alu_src_pc, id_mem_read, id_mem_write;
    logic        id_reg_write, id_branch, id_jalr, id_illegal;
    logic [1:0]  id_wb_sel;

    typedef struct {
        bit          chk_data;
        bit          chk_imm;
        bit          chk_alu;
        logic [31:0] pc, pc4, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        simm, spc, mr, mw, rw, br, jr, ill;
        logic [1:0]  wb;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] regs [32];
    int          checks = 0;
    int          errors = 0;

    id_stage dut (
        .clk(clk), .reset_n(reset_n),
        .pipe_pc(pipe_pc), .pipe_pc4(pipe_pc4), .pipe_data(pipe_data),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .control_j(control_j), .pc_j(pc_j),
        .id_pc(id_pc), .id_pc4(id_pc4),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_alu_op(id_alu_op), .id_alu_src_imm(id_alu_src_imm), .id_alu_src_pc(id_alu_src_pc),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_branch(id_branch), .id_jalr(id_jalr), .id_illegal(id_illegal), .id_wb_sel(id_wb_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Immediates built arithmetically from their weighted bit fields.
    function automatic logic [31:0] immI(input logic [31:0] ins);
        return 32'((ins[31] ? -2048 : 0) + int'(ins[30:20]));
    endfunction
    function automatic logic [31:0] immS(input logic [31:0] ins);
        return 32'((ins[31] ? -2048 : 0) + 32 * int'(ins[30:25]) + int'(ins[11:7]));
    endfunction
    function automatic logic [31:0] immB(input logic [31:0] ins);
        return 32'((ins[31] ? -4096 : 0) + 2048 * int'(ins[7]) + 32 * int'(ins[30:25]) + 2 * int'(ins[11:8]));
    endfunction
    function automatic logic [31:0] immU(input logic [31:0] ins);
        return ins & 32'hFFFF_F000;
    endfunction
    function automatic logic [31:0] immJ(input logic [31:0] ins);
        return 32'((ins[31] ? -1048576 : 0) + 4096 * int'(ins[19:12]) + 2048 * int'(ins[20]) + 2 * int'(ins[30:21]));
    endfunction

    function automatic logic [3:0] aluOf(input logic [2:0] f3, input logic b30, input bit isReg);
        int base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int v = base[f3];
        if (f3 == 3'd0 && isReg && b30) v = 1;
        if (f3 == 3'd5 && b30) v = 7;
        return 4'(v);
    endfunction

    function automatic logic [31:0] readReg(input logic [4:0] r, input logic we,
                                            input logic [4:0] wr, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (we && wr == r) return wd;
        return regs[r];
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic exr, input logic [31:0] d1, input logic [31:0] d2);
        exp_t e = '{default: '0};
        bit legal = 1'b1;
        e.chk_data = 1; e.chk_imm = 1; e.chk_alu = 1;
        e.pc = pc; e.pc4 = pc + 32'd4; e.rs1d = d1; e.rs2d = d2;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = ins[14:12];
        case (ins[6:0])
            7'h37: begin e.rw = 1; e.imm = immU(ins); e.alu = 4'd10; e.simm = 1; end
            7'h17: begin e.rw = 1; e.imm = immU(ins); e.alu = 4'd0; e.simm = 1; e.spc = 1; end
            7'h6F: begin e.rw = 1; e.imm = immJ(ins); e.wb = 2; e.chk_alu = 0; end
            7'h67: begin e.rw = 1; e.imm = immI(ins); e.jr = 1; e.wb = 2; e.alu = 4'd0; e.simm = 1; end
            7'h63: begin e.br = 1; e.imm = immB(ins); e.chk_alu = 0; end
            7'h03: begin e.rw = 1; e.mr = 1; e.wb = 1; e.imm = immI(ins); e.alu = 4'd0; e.simm = 1; end
            7'h23: begin e.mw = 1; e.imm = immS(ins); e.alu = 4'd0; e.simm = 1; end
            7'h13: begin e.rw = 1; e.imm = immI(ins); e.simm = 1; e.alu = aluOf(ins[14:12], ins[30], 0); end
            7'h33: begin e.rw = 1; e.chk_imm = 0; e.alu = aluOf(ins[14:12], ins[30], 1); end
            default: legal = 1'b0;
        endcase
        if (e.rd == 5'd0) e.rw = 0;
        if (ins == 32'd0 || exr || !legal) begin
            e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jr = 0;
            e.chk_data = 0; e.chk_imm = 0; e.chk_alu = 0;
        end
        e.ill = !legal && ins != 32'd0 && !exr;
        return e;
    endfunction

    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc, input logic exr,
                                 input logic [31:0] tgt, input logic we, input logic [4:0] wr,
                                 input logic [31:0] wd);
        logic        cj;
        logic [31:0] pcj;
        pipe_data = ins; pipe_pc = pc; pipe_pc4 = pc + 32'd4;
        ex_redirect = exr; ex_target = tgt;
        wb_we = we; wb_rd = wr; wb_data = wd;
        sb.push_back(model(ins, pc, exr, readReg(ins[19:15], we, wr, wd), readReg(ins[24:20], we, wr, wd)));
        if (we && wr != 5'd0) regs[wr] = wd;
        cj  = exr || ins[6:0] == 7'h6F;
        pcj = exr ? tgt : pc + immJ(ins);
        #1;
        checkOutput("control_j", 32'(control_j), 32'(cj));
        checkOutput("pc_j", pc_j, pcj);
    endtask

    // Monitor: compares the ID/EX bundle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("reg_write", 32'(id_reg_write), 32'(e.rw));
                checkOutput("mem_read", 32'(id_mem_read), 32'(e.mr));
                checkOutput("mem_write", 32'(id_mem_write), 32'(e.mw));
                checkOutput("branch", 32'(id_branch), 32'(e.br));
                checkOutput("jalr", 32'(id_jalr), 32'(e.jr));
                checkOutput("illegal", 32'(id_illegal), 32'(e.ill));
                if (e.chk_data) begin
                    checkOutput("id_pc", id_pc, e.pc);
                    checkOutput("id_pc4", id_pc4, e.pc4);
                    checkOutput("rs1_data", id_rs1_data, e.rs1d);
                    checkOutput("rs2_data", id_rs2_data, e.rs2d);
                    checkOutput("rs1", 32'(id_rs1), 32'(e.rs1));
                    checkOutput("rs2", 32'(id_rs2), 32'(e.rs2));
                    checkOutput("rd", 32'(id_rd), 32'(e.rd));
                    checkOutput("funct3", 32'(id_funct3), 32'(e.f3));
                    checkOutput("wb_sel", 32'(id_wb_sel), 32'(e.wb));
                end
                if (e.chk_imm) checkOutput("imm", id_imm, e.imm);
                if (e.chk_alu) begin
                    checkOutput("alu_op", 32'(id_alu_op), 32'(e.alu));
                    checkOutput("alu_src_imm", 32'(id_alu_src_imm), 32'(e.simm));
                    checkOutput("alu_src_pc", 32'(id_alu_src_pc), 32'(e.spc));
                end
            end
        end
    end

    initial begin
        logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        logic [31:0] r, ins;
        int          sel;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        reset_n = 1'b0;
        pipe_data = 32'h0070_0293; pipe_pc = 32'd0; pipe_pc4 = 32'd4;
        ex_redirect = 1'b0; ex_target = 32'd0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset reg_write", 32'(id_reg_write), 32'd0);
        checkOutput("reset rd", 32'(id_rd), 32'd0);
        checkOutput("reset imm", id_imm, 32'd0);
        checkOutput("reset alu_src_imm", 32'(id_alu_src_imm), 32'd0);
        checkOutput("reset control_j", 32'(control_j), 32'd0);
        reset_n = 1'b1;
        applyStimulus(32'h0070_0293, 32'h80, 0, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(32'h0100_00EF, 32'h84, 0, 0, 0, 0, 0);
        checkOutput("jal target", pc_j, 32'h94);
        @(negedge clk);
        applyStimulus(32'h0031_8233, 32'h88, 0, 0, 1, 5'd3, 32'hDEAD_BEEF);
        @(negedge clk);
        applyStimulus(32'h0000_0313, 32'h8C, 0, 0, 1, 5'd0, 32'd5);
        @(negedge clk);
        applyStimulus(32'h0000_0313, 32'h90, 0, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(32'h0100_00EF, 32'h94, 1, 32'h200, 0, 0, 0);
        checkOutput("redirect target", pc_j, 32'h200);
        @(negedge clk);
        applyStimulus(32'hFFFF_FFFF, 32'h98, 0, 0, 0, 0, 0);

        // Reset in the middle of a cycle with a pending register write.
        @(negedge clk);
        applyStimulus(32'h0010_0393, 32'h9C, 0, 0, 1, 5'd7, 32'h1234_5678);
        #2;
        reset_n = 1'b0;
        sb.delete();
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        #1;
        checkOutput("async reset id_pc", id_pc, 32'd0);
        checkOutput("async reset reg_write", 32'(id_reg_write), 32'd0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(32'h0073_8433, 32'hA0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            r   = $urandom();
            sel = $urandom_range(0, 11);
            if (sel < 9)       ins = {r[31:7], ops[sel]};
            else if (sel == 9) ins = 32'd0;
            else if (sel == 10) ins = $urandom();
            else               ins = {r[31:7], ops[$urandom_range(0, 8)]};
            applyStimulus(ins, {$urandom()} & 32'hFFFF_FFFC, $urandom_range(0, 7) == 0,
                          $urandom(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
        end

        @(negedge clk);
        pipe_data = 32'd0; ex_redirect = 1'b0; wb_we = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
